rv32_register_file: RTL and testbench
=====================================

// Module: rv32_register_file
// PURPOSE
//   RV32I integer register file: 32 x 32-bit registers, two combinational read
//   ports (rs1/rs2) and one clocked write port (rd).
//   Sits in the CPU datapath between decode (register indices) and the ALU/writeback.
//   Register x0 is hardwired to zero.
//   Optional write-to-read forwarding is selected by the BYPASS parameter.
// PARAMETERS
//   XLEN    32  data width of each register, in bits
//   NREGS   32  number of architectural registers (including x0)
//   AW      5   register index width; must equal clog2(NREGS)
//   BYPASS  0   1 = forward same-cycle write data to the read ports; 0 = no forwarding
// PORTS
//   clk  input   1     system clock; all state updates on its rising edge
//   rst  input   1     synchronous, active-high reset
//   we   input   1     write enable
//   rd   input   AW    write register index
//   wd   input   XLEN  write data
//   rs1  input   AW    read port 1 register index
//   rs2  input   AW    read port 2 register index
//   rd1  output  XLEN  read port 1 data (combinational)
//   rd2  output  XLEN  read port 2 data (combinational)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//     * Reset acts on the posedge of clk when rst=1.
//     * Registers x1..x(NREGS-1) clear to 0.
//     * rst has priority over a concurrent write; the write is dropped.
//   - Register state is 0 after reset. Without reset, state is undefined
//     until first written, except x0.
//   - Write: at posedge clk, if rst=0, we=1 and rd!=0, then regs[rd] <= wd.
//     The new value is visible on the read ports after that edge.
//   - Write to x0 (rd=0) is silently ignored; no state changes.
//   - Read: rdN = (rsN==0) ? 0 : regs[rsN]. Purely combinational, zero latency.
//     rdN follows rsN changes within the same cycle.
//   - Both read ports are fully independent.
//     * rs1==rs2 is legal; both ports return the same value.
//   - Read during write to the same index (we=1, rd==rsN, rd!=0):
//     * BYPASS=0: rdN returns the old value until the clock edge.
//     * BYPASS=1: rdN returns wd combinationally.
//     * x0 always reads 0 regardless of BYPASS.
//   - we=0: register contents are held indefinitely. rd and wd are don't-care.
//   - No X propagation from unwritten registers through x0 reads.
//   - rd1 and rd2 have no reset of their own. During and after reset they
//     reflect the cleared registers (0).
// TESTING
//   1. rst=1 for 2 cycles, then rs1=0, rs2=0 -> rd1=0, rd2=0.
//      Then read x5, x31 -> both 0.
//   2. we=1, rd=1, wd=0xDEADBEEF, one posedge, then we=0; rs1=1, rs2=0
//      -> rd1=0xDEADBEEF, rd2=0.
//   3. we=1, rd=0, wd=0xCAFEBABE, one posedge; rs1=0 -> rd1=0.
//      No other register changes.
//   4. Write x2=0x2222 and x3=0x3333 on consecutive cycles.
//      rs1=2, rs2=3 -> 0x2222 / 0x3333; swap indices -> 0x3333 / 0x2222.
//   5. BYPASS=0, x4=0x11 already stored. Set we=1, rd=4, wd=0x99, rs1=4.
//      Before the edge: rd1=0x11; after the edge: rd1=0x99.
//      With BYPASS=1: rd1=0x99 before the edge.
//   6. Write all of x1..x31 with value 0xA5000000|i, then assert rst with
//      we=1, rd=7, wd=0xFFFFFFFF -> every register reads 0 after the edge
//      (reset beats the write).

Source files
------------

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 32 x XLEN, two async reads, one sync write.
// x0 reads zero; optional same-cycle write-to-read forwarding.
module rv32_register_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] r_regs [NREGS-1:1];

  logic w_wr_en;
  logic w_fwd1;
  logic w_fwd2;

  assign w_wr_en = we && (rd != '0);
  assign w_fwd1  = (BYPASS != 0) && w_wr_en && (rd == rs1);
  assign w_fwd2  = (BYPASS != 0) && w_wr_en && (rd == rs2);

  // Register update: reset clears x1..xN-1 and wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[rd] <= wd;
    end
  end

  // Read port 1: x0 forced to zero, optional forwarding of wd.
  always_comb begin
    rd1 = '0;
    if (rs1 != '0) begin
      if (w_fwd1) begin
        rd1 = wd;
      end else begin
        rd1 = r_regs[rs1];
      end
    end
  end

  // Read port 2: same structure as port 1, fully independent.
  always_comb begin
    rd2 = '0;
    if (rs2 != '0) begin
      if (w_fwd2) begin
        rd2 = wd;
      end else begin
        rd2 = r_regs[rs2];
      end
    end
  end

endmodule

// File: tb/tb_rv32_register_file.sv
// Directed bench for rv32_register_file.
// Two instances share stimulus: one without and one with bypass.
module tb_rv32_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] n_rd1;
  logic [31:0] n_rd2;
  logic [31:0] b_rd1;
  logic [31:0] b_rd2;

  int checks;
  int failures;

  rv32_register_file #(.BYPASS(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .rd  (rd),
    .wd  (wd),
    .rs1 (rs1),
    .rs2 (rs2),
    .rd1 (n_rd1),
    .rd2 (n_rd2)
  );

  rv32_register_file #(.BYPASS(1)) u_byp (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .rd  (rd),
    .wd  (wd),
    .rs1 (rs1),
    .rs2 (rs2),
    .rd1 (b_rd1),
    .rd2 (b_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    we  = 1'b0;
    rd  = '0;
    wd  = '0;
    rs1 = '0;
    rs2 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (n_rd1 !== 32'h0 || n_rd2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_x0 rd1=%h rd2=%h want 0/0", n_rd1, n_rd2);
    end
    rs1 = 5'd5;
    rs2 = 5'd31;
    #1;
    checks++;
    if (n_rd1 !== 32'h0 || n_rd2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_x5_x31 rd1=%h rd2=%h want 0/0", n_rd1, n_rd2);
    end
    checks++;
    if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_byp rd1=%h rd2=%h want 0/0", b_rd1, b_rd2);
    end
  endtask

  task automatic test_write();
    we = 1'b1;
    rd = 5'd1;
    wd = 32'hDEADBEEF;
    tick();
    we  = 1'b0;
    rs1 = 5'd1;
    rs2 = 5'd0;
    #1;
    checks++;
    if (n_rd1 !== 32'hDEADBEEF || n_rd2 !== 32'h0) begin
      failures++;
      $display("FAIL write_x1 rd1=%h rd2=%h want deadbeef/0", n_rd1, n_rd2);
    end
    rs2 = 5'd1;
    #1;
    checks++;
    if (n_rd1 !== 32'hDEADBEEF || n_rd2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL same_index rd1=%h rd2=%h want deadbeef", n_rd1, n_rd2);
    end
  endtask

  task automatic test_x0_write();
    we  = 1'b1;
    rd  = 5'd0;
    wd  = 32'hCAFEBABE;
    rs1 = 5'd0;
    rs2 = 5'd1;
    #1;
    checks++;
    if (b_rd1 !== 32'h0) begin
      failures++;
      $display("FAIL x0_bypass rd1=%h want 0", b_rd1);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (n_rd1 !== 32'h0) begin
      failures++;
      $display("FAIL x0_write rd1=%h want 0", n_rd1);
    end
    checks++;
    if (n_rd2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL x0_side_effect x1=%h want deadbeef", n_rd2);
    end
    rs2 = 5'd9;
    #1;
    checks++;
    if (n_rd2 !== 32'h0) begin
      failures++;
      $display("FAIL x0_side_x9 x9=%h want 0", n_rd2);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1;
    rd = 5'd2;
    wd = 32'h2222;
    tick();
    rd = 5'd3;
    wd = 32'h3333;
    tick();
    we  = 1'b0;
    rs1 = 5'd2;
    rs2 = 5'd3;
    #1;
    checks++;
    if (n_rd1 !== 32'h2222 || n_rd2 !== 32'h3333) begin
      failures++;
      $display("FAIL b2b rd1=%h rd2=%h want 2222/3333", n_rd1, n_rd2);
    end
    rs1 = 5'd3;
    rs2 = 5'd2;
    #1;
    checks++;
    if (n_rd1 !== 32'h3333 || n_rd2 !== 32'h2222) begin
      failures++;
      $display("FAIL b2b_swap rd1=%h rd2=%h want 3333/2222", n_rd1, n_rd2);
    end
  endtask

  task automatic test_read_during_write();
    we = 1'b1;
    rd = 5'd4;
    wd = 32'h11;
    tick();
    wd  = 32'h99;
    rs1 = 5'd4;
    rs2 = 5'd2;
    #1;
    checks++;
    if (n_rd1 !== 32'h11) begin
      failures++;
      $display("FAIL rdw_nobyp rd1=%h want 11", n_rd1);
    end
    checks++;
    if (b_rd1 !== 32'h99) begin
      failures++;
      $display("FAIL rdw_byp rd1=%h want 99", b_rd1);
    end
    checks++;
    if (b_rd2 !== 32'h2222) begin
      failures++;
      $display("FAIL rdw_byp_other rd2=%h want 2222", b_rd2);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (n_rd1 !== 32'h99) begin
      failures++;
      $display("FAIL rdw_after rd1=%h want 99", n_rd1);
    end
  endtask

  task automatic test_reset_priority();
    logic [31:0] exp;
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i);
      wd = 32'hA5000000 | 32'(i);
      tick();
    end
    we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(32 - i);
      #1;
      exp = 32'hA5000000 | 32'(i);
      checks++;
      if (n_rd1 !== exp || n_rd2 !== (32'hA5000000 | 32'(32 - i))) begin
        failures++;
        $display("FAIL fill_x%0d rd1=%h rd2=%h want %h", i, n_rd1, n_rd2, exp);
      end
    end
    rst = 1'b1;
    we  = 1'b1;
    rd  = 5'd7;
    wd  = 32'hFFFFFFFF;
    rs1 = 5'd7;
    #1;
    checks++;
    if (n_rd1 !== 32'hA5000007) begin
      failures++;
      $display("FAIL rst_before_edge rd1=%h want a5000007", n_rd1);
    end
    tick();
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      checks++;
      if (n_rd1 !== 32'h0 || n_rd2 !== 32'h0 ||
          b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin
        failures++;
        $display("FAIL rst_clear_x%0d rd1=%h rd2=%h want 0",
                 i, n_rd1, n_rd2);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write();
    test_x0_write();
    test_back_to_back();
    test_read_during_write();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
